counter_datacheck: RTL and testbench
====================================

// Module: counter_datacheck
// PURPOSE
// - Receive-side checker for the loopback link. Takes the 8-bit words from the HPIO RX path
//   (data_to_fabric), finds the bit offset of the word boundary and locks to the incrementing
//   counter pattern sent by counter_datagen.
// - Reports lock, error count and checked-word count for the ILA or a register readout.
// PARAMETERS
// - DATA_W      8   word width; must match counter_datagen
// - LOCK_CNT    16  consecutive good words needed to declare lock
// - UNLOCK_ERR  4   consecutive bad words while locked that force re-search
// - CNT_W       32  width of err_count and word_count
// PORTS
// - clk           in   1       single clock, RX fabric clock (clk_80m); all logic on its rising edge
// - rst           in   1       synchronous, active-high reset
// - din_valid     in   1       din carries a word this cycle (tie to ~fifo_empty or rd_data_valid)
// - din           in   DATA_W  raw received word, MSB first
// - clear_counts  in   1       1-cycle pulse: zero err_count and word_count
// - locked        out  1       pattern lock achieved
// - rot           out  3       bit offset currently in use, 0..DATA_W-1
// - err_pulse     out  1       1-cycle pulse per mismatching word while locked
// - err_count     out  CNT_W   mismatching words while locked; saturates at all-ones
// - word_count    out  CNT_W   words checked while locked; saturates at all-ones
// BEHAVIOUR
// - Reset: locked=0, rot=0, err_pulse=0, err_count=0, word_count=0, state=SEARCH,
//   prev_vld=0, match_cnt=0, miss_cnt=0. Reset applied mid-operation behaves the same;
//   values take effect at the next edge.
// - Alignment: window = {din, prev_din}, 2*DATA_W bits; aligned = window[rot +: DATA_W].
//   On every din_valid, prev_din <= din.
// - First valid word after reset only loads prev_din (prev_vld <= 1). No compare is made.
// - Words with din_valid=0 are ignored; no state or counter changes.
// - exp: expected next aligned word. Arithmetic is modulo 2^DATA_W; 8'hFF+1 wraps to 8'h00.
// - FSM (on each valid word with prev_vld=1):
//   - SEARCH_SEED:
//     - seed <= aligned
//     - -> SEARCH_CHK
//   - SEARCH_CHK:
//     - aligned == seed+1: exp <= aligned+1, match_cnt <= 1, -> CONFIRM
//     - otherwise: rot <= rot+1 (7 wraps to 0), -> SEARCH_SEED
//   - CONFIRM:
//     - aligned == exp: match_cnt++, exp <= aligned+1
//     - when match_cnt reaches LOCK_CNT: -> LOCKED, locked <= 1
//     - mismatch: rot <= rot+1, -> SEARCH_SEED
//   - LOCKED:
//     - aligned == exp: miss_cnt <= 0
//     - mismatch: err_pulse <= 1, err_count++, miss_cnt++
//     - exp <= aligned+1 in both cases, so the checker resyncs to the received value
//       and one corrupted word costs at most 2 errors
//     - word_count++ on every valid word
//     - miss_cnt reaching UNLOCK_ERR: locked <= 0, -> SEARCH_SEED, rot unchanged
// - Latency: err_pulse and counter updates are registered, 1 cycle after the din_valid edge.
//   locked rises 1 cycle after the LOCK_CNT-th matching word is sampled.
// - clear_counts:
//   - has priority over a same-cycle increment; the result is 0 and that increment is lost
//   - does not affect the FSM, rot or locked
// - Saturation: err_count and word_count hold at 2^CNT_W-1 and never wrap.
// - SEARCH cycles through all 8 offsets indefinitely. There is no timeout; locked stays 0.
// STRUCTURE
// - Package loopback_pkg holds: DATA_W default, state enum chk_state_t
//   (SEARCH_SEED, SEARCH_CHK, CONFIRM, LOCKED), ROT_W = $clog2(DATA_W).
// - Sub-module bit_aligner: prev_din register, prev_vld flag, window barrel select.
//   Ports: clk, rst, din_valid, din, rot -> aligned, aligned_vld.
// - Top level holds the FSM, exp/seed registers and saturating counters.
// TESTING
// - Counter 0x00..0xFF repeating, rot offset 0, din_valid=1:
//   locked=1 within 2+16 words, rot=0, err_count=0 after 1000 words.
// - Same stream pre-rotated by 5 bits across word boundaries:
//   locked=1 within 8*2+16+2 words, rot=5, err_count=0.
// - Locked, replace one word with 0x5A:
//   2 err_pulse, err_count=2, locked stays 1, next good words add no errors.
// - Locked, inject 4 consecutive random words (UNLOCK_ERR=4):
//   locked=0 one cycle after the 4th, then relock with the same rot.
// - din_valid toggling 1/0 every cycle on a clean stream:
//   lock and counts identical to the gap-free case, word_count = number of valid words.
// - Reset pulse while locked, and clear_counts coincident with an error:
//   all outputs return to reset values; err_count=0 after clear.

Source files
------------

// File: rtl/loopback_pkg.sv
`default_nettype none
//==============================================================================
// Package : loopback_pkg
// Brief   : Shared widths and checker state encoding for the loopback link.
// Rev     : 1.0 - initial release
//==============================================================================
package loopback_pkg;

    localparam int LB_DATA_W = 8;
    localparam int ROT_W     = $clog2(LB_DATA_W);

    typedef enum logic [1:0] {
        SEARCH_SEED = 2'd0,
        SEARCH_CHK  = 2'd1,
        CONFIRM     = 2'd2,
        LOCKED      = 2'd3
    } chk_state_t;

endpackage
`default_nettype wire

// File: rtl/counter_datacheck_bit_aligner.sv
`default_nettype none
//==============================================================================
// Module : bit_aligner
// Brief  : Holds the previous RX word and selects a DATA_W-bit window at rot.
// Rev    : 1.0 - initial release
//==============================================================================
module bit_aligner
    import loopback_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic [ROT_W-1:0]  rot,
    output logic [DATA_W-1:0] aligned,
    output logic              aligned_vld
);

    logic [DATA_W-1:0]   r_prev_din;
    logic                r_prev_vld;
    logic [2*DATA_W-1:0] w_window;
    logic [ROT_W:0]      w_base;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_din <= '0;
            r_prev_vld <= 1'b0;
        end else if (din_valid) begin
            r_prev_din <= din;
            r_prev_vld <= 1'b1;
        end
    end

    // Older word occupies the low half, so rot=0 selects the previous word intact.
    assign w_window    = {din, r_prev_din};
    assign w_base      = {1'b0, rot};
    assign aligned     = w_window[w_base +: DATA_W];
    assign aligned_vld = din_valid & r_prev_vld;

endmodule
`default_nettype wire

// File: rtl/counter_datacheck.sv
`default_nettype none
//==============================================================================
// Module : counter_datacheck
// Brief  : RX-side checker that bit-aligns and locks to the incrementing counter.
// Rev    : 1.0 - initial release
//==============================================================================
module counter_datacheck
    import loopback_pkg::*;
#(
    parameter int DATA_W     = LB_DATA_W,
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_ERR = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              clear_counts,
    output logic              locked,
    output logic [ROT_W-1:0]  rot,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(UNLOCK_ERR + 1);
    localparam logic [MW-1:0] c_lock_cnt   = MW'(LOCK_CNT);
    localparam logic [EW-1:0] c_unlock_err = EW'(UNLOCK_ERR);

    chk_state_t        r_state, w_state_nxt;
    logic [ROT_W-1:0]  r_rot, w_rot_nxt;
    logic [DATA_W-1:0] r_seed, w_seed_nxt;
    logic [DATA_W-1:0] r_exp, w_exp_nxt;
    logic [MW-1:0]     r_match_cnt, w_match_nxt;
    logic [EW-1:0]     r_miss_cnt, w_miss_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_err_pulse, w_err_pulse_nxt;
    logic [CNT_W-1:0]  r_err_count, r_word_count;
    logic              w_err_inc, w_word_inc;

    logic [DATA_W-1:0] w_aligned;
    logic              w_aligned_vld;
    logic [DATA_W-1:0] w_aligned_inc, w_seed_inc;
    logic [MW-1:0]     w_match_inc;
    logic [EW-1:0]     w_miss_inc;

    bit_aligner #(
        .DATA_W (DATA_W)
    ) u_bit_aligner (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .rot         (r_rot),
        .aligned     (w_aligned),
        .aligned_vld (w_aligned_vld)
    );

    assign w_aligned_inc = w_aligned + DATA_W'(1);
    assign w_seed_inc    = r_seed + DATA_W'(1);
    assign w_match_inc   = r_match_cnt + MW'(1);
    assign w_miss_inc    = r_miss_cnt + EW'(1);

    always_comb begin
        w_state_nxt     = r_state;
        w_rot_nxt       = r_rot;
        w_seed_nxt      = r_seed;
        w_exp_nxt       = r_exp;
        w_match_nxt     = r_match_cnt;
        w_miss_nxt      = r_miss_cnt;
        w_locked_nxt    = r_locked;
        w_err_pulse_nxt = 1'b0;
        w_err_inc       = 1'b0;
        w_word_inc      = 1'b0;
        if (w_aligned_vld) begin
            case (r_state)
                SEARCH_SEED: begin
                    w_seed_nxt  = w_aligned;
                    w_state_nxt = SEARCH_CHK;
                end
                SEARCH_CHK: begin
                    if (w_aligned == w_seed_inc) begin
                        w_exp_nxt   = w_aligned_inc;
                        w_match_nxt = MW'(1);
                        w_state_nxt = CONFIRM;
                    end else begin
                        w_rot_nxt   = r_rot + ROT_W'(1);
                        w_state_nxt = SEARCH_SEED;
                    end
                end
                CONFIRM: begin
                    if (w_aligned == r_exp) begin
                        w_match_nxt = w_match_inc;
                        w_exp_nxt   = w_aligned_inc;
                        if (w_match_inc == c_lock_cnt) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                            w_miss_nxt   = '0;
                        end
                    end else begin
                        w_rot_nxt   = r_rot + ROT_W'(1);
                        w_state_nxt = SEARCH_SEED;
                    end
                end
                LOCKED: begin
                    // Always resync to the received value so one bad word costs at most two errors.
                    w_exp_nxt  = w_aligned_inc;
                    w_word_inc = 1'b1;
                    if (w_aligned == r_exp) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_pulse_nxt = 1'b1;
                        w_err_inc       = 1'b1;
                        w_miss_nxt      = w_miss_inc;
                        if (w_miss_inc == c_unlock_err) begin
                            w_locked_nxt = 1'b0;
                            w_state_nxt  = SEARCH_SEED;
                        end
                    end
                end
                default: w_state_nxt = SEARCH_SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SEARCH_SEED;
            r_rot       <= '0;
            r_seed      <= '0;
            r_exp       <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rot       <= w_rot_nxt;
            r_seed      <= w_seed_nxt;
            r_exp       <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pulse <= w_err_pulse_nxt;
        end
    end

    // Clear wins over a same-cycle increment; counters hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clear_counts) begin
            r_err_count  <= '0;
            r_word_count <= '0;
        end else begin
            if (w_err_inc && (r_err_count != '1))
                r_err_count <= r_err_count + CNT_W'(1);
            if (w_word_inc && (r_word_count != '1))
                r_word_count <= r_word_count + CNT_W'(1);
        end
    end

    assign locked     = r_locked;
    assign rot        = r_rot;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;
    assign word_count = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_datacheck.sv
`default_nettype none
//==============================================================================
// Module : tb_counter_datacheck
// Brief  : Randomized and directed bench for counter_datacheck with a reference model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_counter_datacheck;

    localparam int DATA_W     = 8;
    localparam int LOCK_CNT   = 16;
    localparam int UNLOCK_ERR = 4;
    localparam int CNT_W      = 10;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              din_valid;
    logic [DATA_W-1:0] din;
    logic              clear_counts;
    logic              locked;
    logic [2:0]        rot;
    logic              err_pulse;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  word_count;

    counter_datacheck #(
        .DATA_W     (DATA_W),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_ERR (UNLOCK_ERR),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din_valid    (din_valid),
        .din          (din),
        .clear_counts (clear_counts),
        .locked       (locked),
        .rot          (rot),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .word_count   (word_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: phase 0=seed,1=check,2=confirm,3=locked
    int m_prev = 0, m_pvld = 0, m_phase = 0, m_rot = 0, m_seed = 0, m_exp = 0;
    int m_match = 0, m_miss = 0, m_locked = 0, m_errp = 0, m_errc = 0, m_wc = 0;

    int tx_c = 0;
    int tx_prev = 255;

    always @(posedge clk) begin
        int a;
        bit inc_e, inc_w;
        inc_e = 0;
        inc_w = 0;
        m_errp = 0;
        if (rst) begin
            m_prev = 0; m_pvld = 0; m_phase = 0; m_rot = 0; m_seed = 0; m_exp = 0;
            m_match = 0; m_miss = 0; m_locked = 0; m_errc = 0; m_wc = 0;
        end else begin
            if (din_valid) begin
                if (m_pvld != 0) begin
                    a = (((int'(din) << 8) | m_prev) >> m_rot) & 255;
                    case (m_phase)
                        0: begin m_seed = a; m_phase = 1; end
                        1: if (a == ((m_seed + 1) & 255)) begin
                               m_exp = (a + 1) & 255; m_match = 1; m_phase = 2;
                           end else begin
                               m_rot = (m_rot + 1) % 8; m_phase = 0;
                           end
                        2: if (a == m_exp) begin
                               m_match++; m_exp = (a + 1) & 255;
                               if (m_match == LOCK_CNT) begin m_phase = 3; m_locked = 1; m_miss = 0; end
                           end else begin
                               m_rot = (m_rot + 1) % 8; m_phase = 0;
                           end
                        default: begin
                            inc_w = 1;
                            if (a == m_exp) m_miss = 0;
                            else begin m_errp = 1; inc_e = 1; m_miss++; end
                            m_exp = (a + 1) & 255;
                            if (m_miss == UNLOCK_ERR) begin m_locked = 0; m_phase = 0; end
                        end
                    endcase
                end
                m_pvld = 1;
                m_prev = int'(din);
            end
            if (clear_counts) begin
                m_errc = 0; m_wc = 0;
            end else begin
                if (inc_e && m_errc < CMAX) m_errc++;
                if (inc_w && m_wc < CMAX) m_wc++;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_locked", locked, m_locked);
            check("model_rot", rot, m_rot);
            check("model_err_pulse", err_pulse, m_errp);
            check("model_err_count", err_count, m_errc);
            check("model_word_count", word_count, m_wc);
        end
    end

    function automatic logic [7:0] stream_word(input int c, input int cp, input int r);
        logic [15:0] pair;
        logic [15:0] s;
        pair = {c[7:0], cp[7:0]};
        s = pair >> (8 - r);
        return s[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input int r, input bit v);
        if (v) begin
            din = stream_word(tx_c, tx_prev, r);
            tx_prev = tx_c;
            tx_c = (tx_c + 1) & 255;
        end else begin
            din = 8'($urandom);
        end
        din_valid = v;
        tick();
    endtask

    task automatic send_replace(input logic [7:0] d);
        tx_prev = tx_c;
        tx_c = (tx_c + 1) & 255;
        din = d;
        din_valid = 1'b1;
        tick();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        din_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lock_at, pulses, nv;
        rst = 1'b1; din_valid = 1'b0; din = '0; clear_counts = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset_locked", locked, 0);
        check("reset_rot", rot, 0);
        check("reset_err_count", err_count, 0);
        check("reset_word_count", word_count, 0);

        // Clean counter at offset 0
        lock_at = -1;
        for (int i = 0; i < 1000; i++) begin
            send_clean(0, 1'b1);
            if (lock_at < 0 && locked) lock_at = i + 1;
        end
        check("lock_words_rot0", lock_at, 18);
        check("rot0_rot", rot, 0);
        check("rot0_err_count", err_count, 0);
        check("rot0_word_count", word_count, 982);

        // Single corrupted word
        pulses = 0;
        send_replace(8'h5A);
        pulses += int'(err_pulse);
        for (int i = 0; i < 10; i++) begin
            send_clean(0, 1'b1);
            pulses += int'(err_pulse);
        end
        check("single_err_pulses", pulses, 2);
        check("single_err_count", err_count, 2);
        check("single_err_locked", locked, 1);

        // Four consecutive bad words force re-search
        send_replace(8'h11);
        send_replace(8'h77);
        send_replace(8'hC3);
        send_replace(8'h3C);
        check("burst_still_locked", locked, 1);
        send_clean(0, 1'b1);
        check("burst_unlocked", locked, 0);
        check("burst_err_count", err_count, 6);
        for (int i = 0; i < 30; i++) send_clean(0, 1'b1);
        check("relock_locked", locked, 1);
        check("relock_rot", rot, 0);

        // clear_counts coincident with an error increment
        send_replace(8'h5A);
        clear_counts = 1'b1;
        send_clean(0, 1'b1);
        clear_counts = 1'b0;
        check("clear_err_count", err_count, 0);
        check("clear_word_count", word_count, 0);
        check("clear_err_pulse", err_pulse, 1);
        check("clear_locked", locked, 1);
        send_clean(0, 1'b1);
        check("after_clear_err_count", err_count, 1);

        // Reset while locked
        rst = 1'b1;
        send_clean(0, 1'b1);
        rst = 1'b0;
        check("midreset_locked", locked, 0);
        check("midreset_err_count", err_count, 0);
        check("midreset_word_count", word_count, 0);
        check("midreset_err_pulse", err_pulse, 0);

        // Valid toggling every cycle
        pulse_reset();
        nv = 0; lock_at = -1;
        for (int i = 0; i < 800; i++) begin
            send_clean(0, (i % 2) == 0);
            if ((i % 2) == 0) nv++;
            if (lock_at < 0 && locked) lock_at = nv;
        end
        check("gappy_lock_words", lock_at, 18);
        check("gappy_word_count", word_count, 400 - 18);
        check("gappy_err_count", err_count, 0);

        // Stream rotated by 5 bits
        pulse_reset();
        lock_at = -1;
        for (int i = 0; i < 200; i++) begin
            send_clean(5, 1'b1);
            if (lock_at < 0 && locked) lock_at = i + 1;
        end
        check("rot5_lock_in_budget", (lock_at > 0 && lock_at <= 34), 1);
        check("rot5_rot", rot, 5);
        check("rot5_err_count", err_count, 0);

        // Word counter saturation
        for (int i = 0; i < 1100; i++) send_clean(5, 1'b1);
        check("sat_word_count", word_count, CMAX);

        // Randomized segments
        for (int seg = 0; seg < 6; seg++) begin
            int r;
            r = $urandom_range(0, 7);
            pulse_reset();
            for (int i = 0; i < 500; i++) begin
                bit v;
                v = ($urandom_range(0, 3) != 0);
                clear_counts = ($urandom_range(0, 99) == 0);
                if (v && $urandom_range(0, 49) == 0) send_replace(8'($urandom));
                else send_clean(r, v);
                clear_counts = 1'b0;
            end
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
